// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot cycle, stall hold, branch/jump redirect, saturating redirect counter.
// Optional branch-likely nullification is enabled by defining PC_SEQ_LIKELY_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_d,
  input  logic             br_en,
  input  logic             cmp_out,
  input  logic [31:0]      br_offset,
  input  logic             jmp_en,
  input  logic [31:0]      jmp_target,
  input  logic [31:0]      pc_d,
`ifdef PC_SEQ_LIKELY_EN
  input  logic             br_likely,
`endif
  output logic [31:0]      pc_f,
  output logic             pc_f_valid,
  output logic             redirect,
  output logic [31:0]      link_addr,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic             flush_f
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc_f;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_active;
  logic               w_advance;
  logic               w_br_taken;
  logic               w_redirect;
  logic [31:0]        w_off_sh;
  logic [31:0]        w_br_target;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        w_pc_load;

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign w_advance   = w_active && !stall_d;
  assign w_br_taken  = br_en && cmp_out;
  assign w_redirect  = w_advance && (jmp_en || w_br_taken);
  assign w_off_sh    = br_offset << 2;
  assign w_br_target = pc_d + 32'd4 + w_off_sh;

  // Jump outranks a branch when the decoder (wrongly) asserts both.
  always_comb begin
    w_pc_nxt = r_pc_f + 32'd4;
    if (jmp_en) begin
      w_pc_nxt = jmp_target;
    end else if (w_br_taken) begin
      w_pc_nxt = w_br_target;
    end
  end

  assign w_pc_load = w_pc_nxt & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = stall_d ? ST_HOLD : ST_RUN;
      ST_HOLD: w_state_nxt = stall_d ? ST_HOLD : ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The PC only moves on non-stalled RUN/HOLD cycles; BOOT keeps RESET_PC for the first fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_f <= RESET_PC;
    end else if (w_advance) begin
      r_pc_f <= w_pc_load;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_redirect && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pc_f         = r_pc_f;
  assign pc_f_valid   = w_active;
  assign redirect     = w_redirect;
  assign link_addr    = pc_d + 32'd8;
  assign br_taken_cnt = r_cnt;

`ifdef PC_SEQ_LIKELY_EN
  // A not-taken branch-likely squashes its delay slot; the PC still falls through.
  assign flush_f = w_advance && br_en && br_likely && !cmp_out;
`else
  assign flush_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them. A CNT_W=2 instance shares stimulus for saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_d = 1'b0;
  logic        br_en = 1'b0;
  logic        cmp_out = 1'b0;
  logic [31:0] br_offset = '0;
  logic        jmp_en = 1'b0;
  logic [31:0] jmp_target = '0;
  logic [31:0] pc_d = '0;
  logic        br_likely = 1'b0;

  logic [31:0] pc_f, pc_f2, link_addr, link_addr2;
  logic        pc_f_valid, pc_f_valid2, redirect, redirect2, flush_f, flush_f2;
  logic [15:0] br_taken_cnt;
  logic [1:0]  br_taken_cnt2;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .stall_d(stall_d), .br_en(br_en), .cmp_out(cmp_out),
    .br_offset(br_offset), .jmp_en(jmp_en), .jmp_target(jmp_target), .pc_d(pc_d),
`ifdef PC_SEQ_LIKELY_EN
    .br_likely(br_likely),
`endif
    .pc_f(pc_f), .pc_f_valid(pc_f_valid), .redirect(redirect), .link_addr(link_addr),
    .br_taken_cnt(br_taken_cnt), .flush_f(flush_f)
  );

  pc_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall_d(stall_d), .br_en(br_en), .cmp_out(cmp_out),
    .br_offset(br_offset), .jmp_en(jmp_en), .jmp_target(jmp_target), .pc_d(pc_d),
`ifdef PC_SEQ_LIKELY_EN
    .br_likely(br_likely),
`endif
    .pc_f(pc_f2), .pc_f_valid(pc_f_valid2), .redirect(redirect2), .link_addr(link_addr2),
    .br_taken_cnt(br_taken_cnt2), .flush_f(flush_f2)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        vld;
    logic        rd;
    logic        fl;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [31:0] link;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drv_done = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %h required %h", nm, fld, got, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle against every output.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc_f",         pc_f,                  e.pc);
      chk(e.name, "pc_f_valid",   {31'd0, pc_f_valid},   {31'd0, e.vld});
      chk(e.name, "redirect",     {31'd0, redirect},     {31'd0, e.rd});
      chk(e.name, "flush_f",      {31'd0, flush_f},      {31'd0, e.fl});
      chk(e.name, "br_taken_cnt", {16'd0, br_taken_cnt}, {16'd0, e.cnt});
      chk(e.name, "link_addr",    link_addr,             e.link);
      chk(e.name, "cnt_w2",       {30'd0, br_taken_cnt2}, {30'd0, e.cnt2});
      chk(e.name, "pc_f_w2",      pc_f2,                 e.pc);
    end
  end

  task automatic step(input string nm, input logic rn, input logic st, input logic br,
                      input logic cmp, input logic lk, input logic [31:0] off, input logic jm,
                      input logic [31:0] tgt, input logic [31:0] pcd,
                      input logic [31:0] e_pc, input logic e_v, input logic e_rd,
                      input logic e_fl, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rn; stall_d = st; br_en = br; cmp_out = cmp; br_likely = lk;
    br_offset = off; jmp_en = jm; jmp_target = tgt; pc_d = pcd;
    e.name = nm; e.pc = e_pc; e.vld = e_v; e.rd = e_rd; e.fl = e_fl; e.cnt = e_cnt;
    e.cnt2 = (e_cnt > 16'd3) ? 2'd3 : e_cnt[1:0];
    e.link = pcd + 32'd8;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name          rn st br cm lk off           jm tgt           pc_d          exp_pc        v  rd fl cnt
    step("reset",       0, 0, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3000, 0, 0, 0, 16'd0);
    step("boot",        1, 0, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3000, 0, 0, 0, 16'd0);
    step("run0",        1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_2FFC, 32'h0000_3000, 1, 0, 0, 16'd0);
    step("run1",        1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_3000, 32'h0000_3004, 1, 0, 0, 16'd0);
    step("br_nt",       1, 0, 1, 0, 0, 32'hFFFF_FFFE, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 0, 0, 16'd0);
    step("br_t",        1, 0, 1, 1, 0, 32'hFFFF_FFFE, 0, 32'h0,        32'h0000_3004, 32'h0000_300C, 1, 1, 0, 16'd0);
    step("br_t_tgt",    1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_300C, 32'h0000_3000, 1, 0, 0, 16'd1);
    step("stall0",      1, 1, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3004, 1, 0, 0, 16'd1);
    step("stall1",      1, 1, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3004, 1, 0, 0, 16'd1);
    step("stall2",      1, 1, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3004, 1, 0, 0, 16'd1);
    step("stall_rel",   1, 0, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 32'h0000_3000, 32'h0000_3004, 1, 1, 0, 16'd1);
    step("jmp_lowbits", 1, 0, 0, 0, 0, 32'h0,        1, 32'h0000_4003, 32'h0000_3004, 32'h0000_4000, 1, 1, 0, 16'd2);
    step("br_and_jmp",  1, 0, 1, 1, 0, 32'h0000_0010, 1, 32'h0000_5000, 32'h0000_4000, 32'h0000_4000, 1, 1, 0, 16'd3);
    step("jmp_top",     1, 0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0000_4000, 32'h0000_5000, 1, 1, 0, 16'd4);
    step("pc_top",      1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_5000, 32'hFFFF_FFFC, 1, 0, 0, 16'd5);
    step("pc_wrap",     1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0, 16'd5);
    step("mid_reset",   0, 0, 0, 0, 0, 32'h0,        1, 32'h0000_8000, 32'h0000_0000, 32'h0000_3000, 0, 0, 0, 16'd0);
    step("reset_hold",  0, 0, 0, 0, 0, 32'h0,        1, 32'h0000_8000, 32'h0000_0000, 32'h0000_3000, 0, 0, 0, 16'd0);
    step("boot2",       1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_0000, 32'h0000_3000, 0, 0, 0, 16'd0);
    step("run2_0",      1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_2FFC, 32'h0000_3000, 1, 0, 0, 16'd0);
`ifdef PC_SEQ_LIKELY_EN
    step("likely_nt",   1, 0, 1, 0, 1, 32'h0000_0004, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 1, 0, 1, 16'd0);
    step("likely_t",    1, 0, 1, 1, 1, 32'h0000_0004, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 1, 0, 16'd0);
    step("likely_tgt",  1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_3008, 32'h0000_3018, 1, 0, 0, 16'd1);
`else
    step("nolikely_nt", 1, 0, 1, 0, 1, 32'h0000_0004, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 1, 0, 0, 16'd0);
    step("nolikely_ft", 1, 0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0000_3004, 32'h0000_3008, 1, 0, 0, 16'd0);
`endif
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (drv_done);
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter sequencer for the five-stage MIPS pipeline. It consumes the decode-stage branch decision (comparator result plus branch/jump qualifiers) and produces the fetch PC every cycle. It honours the single branch delay slot, hazard-unit stalls and a boot cycle after reset, and keeps a saturating taken-branch counter for debug.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch address after reset.
- `CNT_W`, 16, width of taken-branch counter.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall_d`  in  1  hazard-unit stall; freezes F and D.
- `br_en`  in  1  D-stage instruction is a conditional branch.
- `cmp_out`  in  1  branch comparator result for the D-stage instruction (1 = condition true).
- `br_offset`  in  32  sign-extended imm16 of the D-stage branch, not yet shifted.
- `jmp_en`  in  1  D-stage instruction is j/jal/jr.
- `jmp_target`  in  32  absolute jump target (imm26 concatenation or rs value).
- `pc_d`  in  32  PC of the D-stage instruction.
- `pc_f`  out  32  current fetch address.
- `pc_f_valid`  out  1  `pc_f` is a real fetch this cycle.
- `redirect`  out  1  combinational; D-stage control transfer taken this cycle.
- `link_addr`  out  32  `pc_d + 8`, for jal/jalr writeback.
- `br_taken_cnt`  out  CNT_W  saturating count of taken redirects.
- `flush_f`  out  1  nullify F-stage instruction; only under `PC_SEQ_LIKELY_EN`, else tied 0.

## Operation
- The FSM has three states. BOOT, RUN and HOLD are encoded 2'b00, 2'b01 and 2'b10.
- BOOT: entered on reset; `pc_f_valid`=0; unconditionally → RUN next edge.
- RUN: `pc_f_valid`=1. Goes to HOLD when `stall_d`=1. Otherwise it stays in RUN and updates `pc_f`.
- HOLD: `pc_f_valid`=1, `pc_f` held. Returns to RUN when `stall_d`=0; the update is evaluated in that same cycle.
- `redirect` = (state==RUN or HOLD) & !`stall_d` & (`jmp_en` | (`br_en` & `cmp_out`)).
- Next-PC priority:
  - `jmp_en` → `jmp_target`.
  - else taken branch → `pc_d + 4 + (br_offset << 2)`.
  - else `pc_f + 4`.
- All next-PC arithmetic is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- `pc_f[1:0]` is forced to 2'b00 on every load; target low bits are discarded.
- `br_en` and `jmp_en` both asserted is a decoder error. `jmp_en` wins, and the event counts as one redirect.
- While `stall_d`=1, branch and jump inputs are ignored. The D instruction re-presents them after the stall.
- Delay slot: at resolution, the instruction at `pc_f` is the delay slot and always proceeds (base build).
- `br_taken_cnt` increments on each cycle with `redirect`=1. It saturates at all-ones and never wraps.
- `link_addr` = `pc_d + 8`, combinational, modulo 2^32.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `pc_f`=RESET_PC, state=BOOT, `pc_f_valid`=0, `br_taken_cnt`=0, `flush_f`=0.
  - `redirect` follows its equation; it is 0 because state=BOOT.
- First edge after reset release: BOOT→RUN with `pc_f` still RESET_PC. The first valid fetch is RESET_PC.
- Redirect latency is one cycle. `redirect` is high in cycle N, and `pc_f` = target from edge N+1.
- Reset asserted mid-operation aborts immediately. Any pending target is lost and no counter increment occurs.
- Stall release: the first non-stalled cycle may redirect in that same cycle.

## Configuration
- Macro `PC_SEQ_LIKELY_EN` adds branch-likely support.
- With the macro defined:
  - Extra input `br_likely` (1 bit) is added.
  - When `br_en`=1, `br_likely`=1, `cmp_out`=0 and `stall_d`=0, `flush_f` is high that cycle (combinational). This nullifies the delay slot.
  - `pc_f` advances to `pc_f+4` as normal.
- Without the macro: no `br_likely` port, `flush_f` is tied 0, and the delay slot always executes.

## Test plan
- Reset then release:
  - `pc_f`=32'h0000_3000 with `pc_f_valid`=0 for one cycle.
  - Then fetches 3000, 3004, 3008 in consecutive cycles.
- Taken branch: `pc_d`=3004, `br_en`=1, `cmp_out`=1, `br_offset`=32'hFFFF_FFFE. Required: `redirect`=1, next `pc_f`=3000, `br_taken_cnt`=1.
- Not-taken branch: `pc_d`=3004, `br_en`=1, `cmp_out`=0. Required: `pc_f` goes 3008→300C, `redirect`=0, counter unchanged.
- Stall masking:
  - `stall_d`=1 for 3 cycles with `jmp_en`=1 and `jmp_target`=4000. Required: `pc_f` held, no redirect.
  - Release stall. Required: `redirect`=1, then `pc_f`=4000.
- Boundaries:
  - `pc_f`=FFFF_FFFC with no redirect → `pc_f`=0.
  - `jmp_target`=0000_4003 → `pc_f`=0000_4000.
  - `br_en` and `jmp_en` together → `jmp_target` is taken.
  - CNT_W=2 with 5 redirects → `br_taken_cnt`=3.
- With `PC_SEQ_LIKELY_EN` defined: `br_likely`=1, `cmp_out`=0 → `flush_f`=1 for one cycle. With `cmp_out`=1 → `flush_f`=0 and redirect occurs.
